// File: rtl/base_r_encoder.sv
// 64b/66b transmit encoder: classifies each 64-bit MII word, frames it into a
// 66-bit block and tracks frame state, substituting error blocks on protocol violations.
module base_r_encoder #(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  input  logic [63:0]          i_mii_data,
  input  logic [7:0]           i_mii_ctrl,
  output logic                 o_valid,
  output logic [65:0]          o_tx_block,
  output logic                 o_seq_err,
  output logic [ERR_CNT_W-1:0] o_err_count,
  output logic [1:0]           o_fsm_state
);

  // Handshake: i_valid qualifies one MII word per cycle with no backpressure;
  // o_valid follows i_valid exactly one cycle later with the encoded block.

  localparam logic [7:0]  CH_S     = 8'hFB;
  localparam logic [7:0]  CH_T     = 8'hFD;
  localparam logic [7:0]  CH_I     = 8'h07;
  localparam logic [65:0] IDLE_BLK = {56'd0, 8'h1E, 2'b01};
  localparam logic [65:0] ERR_BLK  = {{8{7'h1E}}, 8'h1E, 2'b01};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_ERR   = 2'd2
  } state_t;

  state_t state, state_next;

  logic        is_d, is_s, is_i, is_t, t_ok;
  logic [7:0]  t_type;
  logic [55:0] t_payload;
  logic [65:0] blk_next;
  logic        err_next;

  function automatic logic [7:0] t_type_of(input logic [2:0] k);
    case (k)
      3'd0:    t_type_of = 8'h87;
      3'd1:    t_type_of = 8'h99;
      3'd2:    t_type_of = 8'hAA;
      3'd3:    t_type_of = 8'hB4;
      3'd4:    t_type_of = 8'hCC;
      3'd5:    t_type_of = 8'hD2;
      3'd6:    t_type_of = 8'hE1;
      default: t_type_of = 8'hFF;
    endcase
  endfunction

  // Word classification; at most one terminate position can match a given ctrl mask.
  always_comb begin
    is_d      = (i_mii_ctrl == 8'h00);
    is_s      = (i_mii_ctrl == 8'h01) && (i_mii_data[7:0] == CH_S);
    is_i      = (i_mii_ctrl == 8'hFF) && (i_mii_data == {8{CH_I}});
    is_t      = 1'b0;
    t_ok      = 1'b0;
    t_type    = 8'h00;
    t_payload = 56'd0;
    for (int k = 0; k < 8; k++) begin
      t_ok = (i_mii_ctrl == 8'(8'hFF << k)) && (i_mii_data[8*k +: 8] == CH_T);
      for (int j = 0; j < 8; j++) begin
        if (j > k && i_mii_data[8*j +: 8] != CH_I) t_ok = 1'b0;
      end
      if (t_ok) begin
        is_t   = 1'b1;
        t_type = t_type_of(3'(k));
        for (int j = 0; j < 7; j++) begin
          if (j < k) t_payload[8*j +: 8] = i_mii_data[8*j +: 8];
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    blk_next   = ERR_BLK;
    err_next   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (is_i) begin
          blk_next = IDLE_BLK;
        end else if (is_s) begin
          blk_next   = {i_mii_data[63:8], 8'h78, 2'b01};
          state_next = ST_FRAME;
        end else begin
          err_next   = 1'b1;
          state_next = ST_ERR;
        end
      end
      ST_FRAME: begin
        if (is_d) begin
          blk_next = {i_mii_data, 2'b10};
        end else if (is_t) begin
          blk_next   = {t_payload, t_type, 2'b01};
          state_next = ST_IDLE;
        end else begin
          err_next   = 1'b1;
          state_next = ST_ERR;
        end
      end
      ST_ERR: begin
        if (is_i) begin
          blk_next   = IDLE_BLK;
          state_next = ST_IDLE;
        end else if (is_s) begin
          blk_next   = {i_mii_data[63:8], 8'h78, 2'b01};
          state_next = ST_FRAME;
        end else begin
          err_next = 1'b1;
        end
      end
      default: begin
        err_next   = 1'b1;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      o_valid     <= 1'b0;
      o_seq_err   <= 1'b0;
      o_tx_block  <= IDLE_BLK;
      o_err_count <= '0;
    end else begin
      o_valid   <= i_valid;
      o_seq_err <= i_valid & err_next;
      if (i_valid) begin
        state      <= state_next;
        o_tx_block <= blk_next;
        if (err_next && o_err_count != '1) o_err_count <= o_err_count + 1'b1;
      end
    end
  end

  assign o_fsm_state = state;

endmodule

// File: tb/tb_base_r_encoder.sv
// Directed bench for base_r_encoder: hand-computed blocks for idle, frames, all
// terminate positions, error sequences, valid gaps, counter saturation and reset.
module tb_base_r_encoder;

  localparam logic [65:0] IDLE_BLK = {56'd0, 8'h1E, 2'b01};
  localparam logic [65:0] ERR_BLK  = {{8{7'h1E}}, 8'h1E, 2'b01};
  localparam logic [63:0] I_WORD   = {8{8'h07}};
  localparam logic [63:0] S_WORD   = 64'h55555555_555555FB;
  localparam logic [65:0] S_BLK    = {56'h55555555555555, 8'h78, 2'b01};
  localparam logic [63:0] D_WORD   = 64'h01234567_89ABCDEF;
  localparam logic [65:0] D_BLK    = {64'h01234567_89ABCDEF, 2'b10};
  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_FRAME  = 2'd1;
  localparam logic [1:0]  S_ERR    = 2'd2;

  logic        clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [63:0] i_mii_data = '0;
  logic [7:0]  i_mii_ctrl = '0;

  logic        o_valid, o_seq_err, v2, e2;
  logic [65:0] o_tx_block, b2;
  logic [15:0] o_err_count;
  logic [1:0]  c2;
  logic [1:0]  o_fsm_state, st2;

  int n_checks = 0;
  int n_errors = 0;
  logic [65:0] exp_q[$];

  base_r_encoder #(.ERR_CNT_W(16)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid),
    .i_mii_data(i_mii_data), .i_mii_ctrl(i_mii_ctrl),
    .o_valid(o_valid), .o_tx_block(o_tx_block), .o_seq_err(o_seq_err),
    .o_err_count(o_err_count), .o_fsm_state(o_fsm_state)
  );

  base_r_encoder #(.ERR_CNT_W(2)) dut2 (
    .clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid),
    .i_mii_data(i_mii_data), .i_mii_ctrl(i_mii_ctrl),
    .o_valid(v2), .o_tx_block(b2), .o_seq_err(e2),
    .o_err_count(c2), .o_fsm_state(st2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    #1;
    chk({tag, "_valid"}, 66'(o_valid), 66'(1'b0));
    chk({tag, "_seq_err"}, 66'(o_seq_err), 66'(1'b0));
    chk({tag, "_count"}, 66'(o_err_count), 66'd0);
    chk({tag, "_block"}, o_tx_block, IDLE_BLK);
    chk({tag, "_state"}, 66'(o_fsm_state), 66'(S_IDLE));
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_rst_n = 1'b1;
  endtask

  // Drives one cycle; the expected block goes on the scoreboard queue and is
  // compared after the registering edge.
  task automatic send(input string tag, input logic v, input logic [63:0] d,
                      input logic [7:0] c, input logic [65:0] eb,
                      input logic ee, input logic [1:0] es);
    logic [65:0] exp_blk;
    @(negedge clk);
    i_valid    = v;
    i_mii_data = d;
    i_mii_ctrl = c;
    exp_q.push_back(eb);
    @(posedge clk);
    #1;
    exp_blk = exp_q.pop_front();
    chk({tag, "_valid"}, 66'(o_valid), 66'(v));
    chk({tag, "_block"}, o_tx_block, exp_blk);
    chk({tag, "_seq_err"}, 66'(o_seq_err), 66'(ee));
    chk({tag, "_state"}, 66'(o_fsm_state), 66'(es));
  endtask

  initial begin
    logic [63:0] tw;
    logic [55:0] tp;
    logic [7:0]  tc;
    logic [7:0]  tt [8];
    tt = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};

    do_reset("rst0");

    // Basic frame with T3 carrying AA,BB,CC
    send("f_idle", 1, I_WORD, 8'hFF, IDLE_BLK, 0, S_IDLE);
    send("f_start", 1, S_WORD, 8'h01, S_BLK, 0, S_FRAME);
    send("f_d0", 1, D_WORD, 8'h00, D_BLK, 0, S_FRAME);
    send("f_d1", 1, 64'hFEDCBA98_76543210, 8'h00, {64'hFEDCBA98_76543210, 2'b10}, 0, S_FRAME);
    send("f_t3", 1, 64'h07070707_FDCCBBAA, 8'hF8, {32'd0, 24'hCCBBAA, 8'hB4, 2'b01}, 0, S_IDLE);
    chk("f_count", 66'(o_err_count), 66'd0);

    // Every terminate position
    for (int k = 0; k < 8; k++) begin
      tw = I_WORD;
      tp = '0;
      for (int j = 0; j < 8; j++) begin
        if (j < k) begin
          tw[8*j +: 8] = 8'(8'h11 * (j + 1));
          tp[8*j +: 8] = 8'(8'h11 * (j + 1));
        end
      end
      tw[8*k +: 8] = 8'hFD;
      tc = 8'(8'hFF << k);
      send($sformatf("t%0d_start", k), 1, S_WORD, 8'h01, S_BLK, 0, S_FRAME);
      send($sformatf("t%0d_data", k), 1, D_WORD, 8'h00, D_BLK, 0, S_FRAME);
      send($sformatf("t%0d_term", k), 1, tw, tc, {tp, tt[k], 2'b01}, 0, S_IDLE);
    end

    // D in IDLE, D, then I
    do_reset("rst1");
    send("e_d0", 1, D_WORD, 8'h00, ERR_BLK, 1, S_ERR);
    send("e_d1", 1, D_WORD, 8'h00, ERR_BLK, 1, S_ERR);
    chk("e_count2", 66'(o_err_count), 66'd2);
    send("e_idle", 1, I_WORD, 8'hFF, IDLE_BLK, 0, S_IDLE);
    chk("e_count_hold", 66'(o_err_count), 66'd2);

    // S inside a frame, then a fresh S is accepted
    send("s_start", 1, S_WORD, 8'h01, S_BLK, 0, S_FRAME);
    send("s_dup", 1, S_WORD, 8'h01, ERR_BLK, 1, S_ERR);
    send("s_restart", 1, S_WORD, 8'h01, S_BLK, 0, S_FRAME);
    send("s_t0", 1, 64'h07070707_070707FD, 8'hFF, {56'd0, 8'h87, 2'b01}, 0, S_IDLE);
    // I inside a frame and a bad control character in IDLE
    send("s_start2", 1, S_WORD, 8'h01, S_BLK, 0, S_FRAME);
    send("s_idle_in_frame", 1, I_WORD, 8'hFF, ERR_BLK, 1, S_ERR);
    send("s_recover", 1, I_WORD, 8'hFF, IDLE_BLK, 0, S_IDLE);
    send("s_badctl", 1, 64'h07070707_070707FE, 8'hFF, ERR_BLK, 1, S_ERR);
    chk("s_count", 66'(o_err_count), 66'd5);

    // Valid gap during a frame
    send("g_idle", 1, I_WORD, 8'hFF, IDLE_BLK, 0, S_IDLE);
    send("g_start", 1, S_WORD, 8'h01, S_BLK, 0, S_FRAME);
    send("g_gap", 0, D_WORD, 8'h00, S_BLK, 0, S_FRAME);
    send("g_data", 1, D_WORD, 8'h00, D_BLK, 0, S_FRAME);
    send("g_gap2", 0, 64'h0, 8'hFF, D_BLK, 0, S_FRAME);
    send("g_t7", 1, 64'hFD776655_44332211, 8'h80, {56'h77665544332211, 8'hFF, 2'b01}, 0, S_IDLE);
    chk("g_count", 66'(o_err_count), 66'd5);

    // Saturation on the 2-bit counter instance
    do_reset("rst2");
    for (int n = 1; n <= 5; n++) begin
      send($sformatf("x%0d", n), 1, D_WORD, 8'h55, ERR_BLK, 1, S_ERR);
      chk($sformatf("x%0d_cnt2", n), 66'(c2), 66'((n > 3) ? 3 : n));
      chk($sformatf("x%0d_seq2", n), 66'(e2), 66'(1'b1));
    end
    chk("x_cnt16", 66'(o_err_count), 66'd5);

    // Reset mid-frame, then a D word is an error from IDLE
    send("m_idle", 1, I_WORD, 8'hFF, IDLE_BLK, 0, S_IDLE);
    send("m_start", 1, S_WORD, 8'h01, S_BLK, 0, S_FRAME);
    send("m_data", 1, D_WORD, 8'h00, D_BLK, 0, S_FRAME);
    do_reset("rst3");
    chk("rst3_cnt2", 66'(c2), 66'd0);
    chk("rst3_blk2", b2, IDLE_BLK);
    chk("rst3_valid2", 66'(v2), 66'd0);
    chk("rst3_state2", 66'(st2), 66'(S_IDLE));
    send("m_after", 1, D_WORD, 8'h00, ERR_BLK, 1, S_ERR);
    chk("m_after_count", 66'(o_err_count), 66'd1);

    @(negedge clk);
    i_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("end_valid", 66'(o_valid), 66'd0);
    chk("end_hold", o_tx_block, ERR_BLK);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/base_r_encoder.md
BASE_R_ENCODER -- requirements
Module: base_r_encoder

Interface
REQ-001 Parameter ERR_CNT_W, default 16: width of the saturating sequence-error counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 i_valid  input  1  i_mii_data/i_mii_ctrl hold a valid 64-bit MII word this cycle.
REQ-005 i_mii_data  input  64  MII data; lane k = bits [8k+7:8k], lane 0 transmitted first.
REQ-006 i_mii_ctrl  input  8  MII control; bit k set means lane k is a control character.
REQ-007 o_valid  output  1  o_tx_block valid this cycle.
REQ-008 o_tx_block  output  66  encoded block: [1:0] sync header, [9:2] block type (control blocks), [65:10] payload.
REQ-009 o_seq_err  output  1  one-cycle pulse, coincident with o_valid, when an error block is emitted.
REQ-010 o_err_count  output  ERR_CNT_W  count of emitted error blocks.

Function
REQ-011 Character codes: /S/=8'hFB, /T/=8'hFD, /I/=8'h07; every other control character is invalid.
REQ-012 Sync header: data block [1:0]=2'b10; control block [1:0]=2'b01.
REQ-013 Word classes, evaluated each i_valid cycle:
 - D: ctrl=8'h00 -> block [65:2]=i_mii_data.
 - S: ctrl=8'h01, lane0=/S/ -> type 8'h78, [65:10]=data[63:8].
 - Tk (k=0..7): lane k=/T/, ctrl bits k..7 set, bits 0..k-1 clear, lanes k+1..7=/I/ -> type T0..T7 = 87,99,AA,B4,CC,D2,E1,FF (hex); lanes 0..k-1 copied to [17:10],[25:18],... in order; all remaining payload bits 0.
 - I: ctrl=8'hFF, all lanes /I/ -> type 8'h1E, [65:10]=0.
 - Anything else: class X.
REQ-014 FSM states: IDLE (between frames), FRAME (inside frame), ERR (after violation).
REQ-015 IDLE: I -> idle block, stay; S -> start block, go FRAME; D/T/X -> error block, go ERR.
REQ-016 FRAME: D -> data block, stay; Tk -> terminate block, go IDLE; S/I/X -> error block, go ERR.
REQ-017 ERR: I -> idle block, go IDLE; S -> start block, go FRAME; D/T/X -> error block, stay ERR.
REQ-018 Error block: sync 2'b01, type 8'h1E, payload = eight 7-bit codes 7'h1E at [16:10],[23:17],...,[65:59].
REQ-019 Latency exactly one cycle: o_valid(n+1)=i_valid(n); o_tx_block and o_seq_err registered with it.
REQ-020 i_valid=0: FSM, counter and o_tx_block hold; o_valid=0, o_seq_err=0.
REQ-021 o_err_count increments by 1 per error block and saturates at all-ones (no wrap).
REQ-022 No backpressure; one block accepted and one produced per valid cycle, back-to-back valid supported.

Reset
REQ-023 While i_rst_n=0: o_valid=0, o_seq_err=0, o_err_count=0, FSM=IDLE, o_tx_block = idle block (sync 2'b01, type 8'h1E, payload 0).
REQ-024 Reset asserted mid-frame discards the frame immediately; first word after release is classified from IDLE (D -> error block).

Verification
REQ-025 Frame: I, S(lane0 FB, data 0x55..), D x2, T3 with lanes 0..2 = AA,BB,CC -> idle, type 78, two data blocks sync 2'b10, type B4 with [33:10]=CCBBAA; no o_seq_err.
REQ-026 All eight Tk positions each terminating a start+data frame -> types 87,99,AA,B4,CC,D2,E1,FF, unused payload bits 0.
REQ-027 D word in IDLE, then D, then I -> two error blocks (type 1E, 7'h1E codes), o_seq_err pulses twice, o_err_count=2, then idle block.
REQ-028 S received in FRAME -> error block, FSM ERR; next S -> start block accepted.
REQ-029 i_valid toggling 1,0,1 during a frame -> o_valid 0 in the gap cycle, output block order and FSM unchanged.
REQ-030 ERR_CNT_W=2, five consecutive X words -> o_err_count 1,2,3,3,3; then reset mid-frame -> all outputs at REQ-023 values.
